ysyx_22040750_csr_irq: RTL and testbench

Parametrised machine-mode CSR file with a three-source interrupt controller (software, timer, external) and synchronous exception entry.
- Executes CSRRW/CSRRS/CSRRC read-modify-write internally.
- Sits beside the WB stage; all state updates are qualified by the WB-valid strobe.
- Supplies trap vector, mepc and interrupt requests to the fetch/redirect logic.

---
 rtl/ysyx_22040750_csr_pkg.sv | 35 +++
 rtl/ysyx_22040750_irq_arb.sv | 27 ++
 rtl/ysyx_22040750_csr_irq.sv | 177 +++++++++++++++++
 tb/tb_ysyx_22040750_csr_irq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040750_csr_pkg.sv
// rtl/ysyx_22040750_csr_pkg.sv - CSR addresses, op encodings, interrupt causes, mstatus layout
package ysyx_22040750_csr_pkg;

    localparam logic [11:0] CSR_SATP     = 12'h180;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [63:0] MSTATUS_RESET = 64'h0000000a00001800;

endpackage

// File: rtl/ysyx_22040750_irq_arb.sv
// rtl/ysyx_22040750_irq_arb.sv - fixed-priority machine interrupt arbiter (MEI > MSI > MTI)
module ysyx_22040750_irq_arb
    import ysyx_22040750_csr_pkg::*;
(
    input  logic       msi,
    input  logic       mti,
    input  logic       mei,
    input  logic       global_en,
    input  logic       busy,
    output logic       req,
    output logic [3:0] cause
);

    // Cause tracks the winning source even when masked, so trap entry can record it.
    always_comb begin
        cause = 4'd0;
        if (mei) begin
            cause = CAUSE_MEI;
        end else if (msi) begin
            cause = CAUSE_MSI;
        end else if (mti) begin
            cause = CAUSE_MTI;
        end
        req = (msi | mti | mei) & global_en & ~busy;
    end

endmodule

// File: rtl/ysyx_22040750_csr_irq.sv
// rtl/ysyx_22040750_csr_irq.sv - M-mode CSR file, trap entry/mret and interrupt requests
// CSR_COUNTERS_EN adds mcycle/minstret.
module ysyx_22040750_csr_irq
    import ysyx_22040750_csr_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int PC_W   = 32,
    parameter int HARTID = 0
) (
    input  logic            I_sys_clk,
    input  logic            I_rst,
    input  logic            I_msip,
    input  logic            I_mtip,
    input  logic            I_meip,
    input  logic            I_pipe_busy,
    input  logic            I_wb_valid,
    input  logic [1:0]      I_csr_op,
    input  logic [11:0]     I_csr_addr,
    input  logic [XLEN-1:0] I_csr_src,
    output logic [XLEN-1:0] O_csr_rdata,
    output logic            O_csr_illegal,
    input  logic            I_exc_valid,
    input  logic [3:0]      I_exc_cause,
    input  logic [XLEN-1:0] I_exc_tval,
    input  logic            I_irq_take,
    input  logic [PC_W-1:0] I_trap_pc,
    input  logic            I_mret,
    input  logic            I_retire,
    output logic            O_irq_req,
    output logic [3:0]      O_irq_cause,
    output logic [PC_W-1:0] O_trap_vec,
    output logic [PC_W-1:0] O_mepc
);

    logic [XLEN-1:0] mstatus, mie, mtvec, mscratch, mcause, mtval, satp;
    logic [PC_W-1:0] mepc;
    logic            mip_msi, mip_mti, mip_mei;
    logic [XLEN-1:0] mip_word, rdata, wdata;
    logic            exists, read_only, is_write, trap, do_mret, csr_we;
    logic [3:0]      arb_cause;
    logic [PC_W-1:0] vec_base;
    csr_op_e         op;

`ifdef CSR_COUNTERS_EN
    logic [XLEN-1:0] mcycle, minstret;
`else
    logic unused_retire;
    assign unused_retire = I_retire;
`endif
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^I_trap_pc[1:0];

    assign op       = csr_op_e'(I_csr_op);
    assign mip_word = XLEN'({mip_mei, 3'b000, mip_mti, 3'b000, mip_msi, 3'b000});

    always_comb begin
        rdata     = '0;
        exists    = 1'b1;
        read_only = 1'b0;
        case (I_csr_addr)
            CSR_MSTATUS:  rdata = mstatus;
            CSR_MIE:      rdata = mie;
            CSR_MTVEC:    rdata = mtvec;
            CSR_MSCRATCH: rdata = mscratch;
            CSR_MEPC:     rdata = XLEN'(mepc);
            CSR_MCAUSE:   rdata = mcause;
            CSR_MTVAL:    rdata = mtval;
            CSR_SATP:     rdata = satp;
            CSR_MIP:      begin rdata = mip_word;       read_only = 1'b1; end
            CSR_MHARTID:  begin rdata = XLEN'(HARTID);  read_only = 1'b1; end
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:   rdata = mcycle;
            CSR_MINSTRET: rdata = minstret;
`endif
            default:      exists = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            OP_RW:   wdata = I_csr_src;
            OP_RS:   wdata = rdata | I_csr_src;
            OP_RC:   wdata = rdata & ~I_csr_src;
            default: wdata = rdata;
        endcase
    end

    // RS/RC with a zero operand is a pure read, so it is legal even on read-only CSRs.
    assign is_write      = (op == OP_RW) || (|I_csr_src);
    assign O_csr_illegal = (op != OP_NONE) && (!exists || (read_only && is_write));
    assign O_csr_rdata   = rdata;

    assign trap    = I_wb_valid & (I_exc_valid | I_irq_take);
    assign do_mret = I_wb_valid & I_mret & ~trap;
    assign csr_we  = I_wb_valid & (op != OP_NONE) & is_write & ~O_csr_illegal & ~trap & ~I_mret;

    ysyx_22040750_irq_arb u_irq_arb (
        .msi       (mip_msi & mie[3]),
        .mti       (mip_mti & mie[7]),
        .mei       (mip_mei & mie[11]),
        .global_en (mstatus[MSTATUS_MIE]),
        .busy      (I_pipe_busy),
        .req       (O_irq_req),
        .cause     (arb_cause)
    );
    assign O_irq_cause = arb_cause;

    assign vec_base   = {mtvec[PC_W-1:2], 2'b00};
    assign O_trap_vec = (mtvec[0] & I_wb_valid & I_irq_take & ~I_exc_valid)
                      ? vec_base + {{(PC_W-6){1'b0}}, arb_cause, 2'b00}
                      : vec_base;
    assign O_mepc     = mepc;

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            mstatus  <= XLEN'(MSTATUS_RESET);
            mie      <= '0;
            mtvec    <= '0;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
            satp     <= '0;
            mip_msi  <= 1'b0;
            mip_mti  <= 1'b0;
            mip_mei  <= 1'b0;
        end else begin
            mip_msi <= I_msip;
            mip_mti <= I_mtip;
            mip_mei <= I_meip;
            if (trap) begin
                mepc   <= {I_trap_pc[PC_W-1:2], 2'b00};
                mcause <= I_exc_valid ? XLEN'(I_exc_cause) : {1'b1, {(XLEN-5){1'b0}}, arb_cause};
                mtval  <= I_exc_valid ? I_exc_tval : '0;
                mstatus[MSTATUS_MPIE] <= mstatus[MSTATUS_MIE];
                mstatus[MSTATUS_MIE]  <= 1'b0;
            end else if (do_mret) begin
                mstatus[MSTATUS_MIE]  <= mstatus[MSTATUS_MPIE];
                mstatus[MSTATUS_MPIE] <= 1'b1;
            end else if (csr_we) begin
                case (I_csr_addr)
                    CSR_MSTATUS:  mstatus  <= {wdata[XLEN-1:MSTATUS_MPP_HI+1], 2'b11,
                                               wdata[MSTATUS_MPP_LO-1:0]};
                    CSR_MIE:      mie      <= wdata;
                    CSR_MTVEC:    mtvec    <= {wdata[XLEN-1:2], 1'b0, wdata[0]};
                    CSR_MSCRATCH: mscratch <= wdata;
                    CSR_MEPC:     mepc     <= {wdata[PC_W-1:2], 2'b00};
                    CSR_MCAUSE:   mcause   <= wdata;
                    CSR_MTVAL:    mtval    <= wdata;
                    CSR_SATP:     satp     <= wdata;
                    default:      ;
                endcase
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (csr_we && I_csr_addr == CSR_MCYCLE) begin
                mcycle <= wdata;
            end else begin
                mcycle <= mcycle + XLEN'(1);
            end
            if (csr_we && I_csr_addr == CSR_MINSTRET) begin
                minstret <= wdata;
            end else if (I_wb_valid && I_retire) begin
                minstret <= minstret + XLEN'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22040750_csr_irq.sv
// tb/tb_ysyx_22040750_csr_irq.sv - bench for ysyx_22040750_csr_irq against a behavioural CSR model
`timescale 1ns/1ps
module tb_ysyx_22040750_csr_irq;

`ifdef CSR_COUNTERS_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        msip, mtip, meip, pipe_busy, wb_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [63:0] csr_src, csr_rdata, exc_tval;
    logic        csr_illegal, exc_valid, irq_take, mret, retire, irq_req;
    logic [3:0]  exc_cause, irq_cause;
    logic [31:0] trap_pc, trap_vec, mepc_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_22040750_csr_irq #(.XLEN(64), .PC_W(32), .HARTID(0)) dut (
        .I_sys_clk(clk), .I_rst(rst),
        .I_msip(msip), .I_mtip(mtip), .I_meip(meip), .I_pipe_busy(pipe_busy),
        .I_wb_valid(wb_valid), .I_csr_op(csr_op), .I_csr_addr(csr_addr), .I_csr_src(csr_src),
        .O_csr_rdata(csr_rdata), .O_csr_illegal(csr_illegal),
        .I_exc_valid(exc_valid), .I_exc_cause(exc_cause), .I_exc_tval(exc_tval),
        .I_irq_take(irq_take), .I_trap_pc(trap_pc), .I_mret(mret), .I_retire(retire),
        .O_irq_req(irq_req), .O_irq_cause(irq_cause), .O_trap_vec(trap_vec), .O_mepc(mepc_out)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Architectural model: one variable per CSR, updated by the trap/mret/CSR rules.
    logic [63:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_satp, m_mip, m_mcycle, m_minstret;
    bit          m_valid = 1'b0;

    function automatic logic [63:0] m_rd(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return m_mip;
            12'h180: return m_satp;
            12'hB00: return CNT ? m_mcycle : 64'd0;
            12'hB02: return CNT ? m_minstret : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    function automatic bit m_exists(input logic [11:0] a);
        if (a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                      12'h344, 12'hF14, 12'h180}) return 1'b1;
        return CNT && (a == 12'hB00 || a == 12'hB02);
    endfunction

    function automatic bit m_illegal();
        bit ro;
        ro = (csr_addr == 12'h344) || (csr_addr == 12'hF14);
        if (csr_op == 2'b00) return 1'b0;
        return !m_exists(csr_addr) || (ro && (csr_op == 2'b01 || csr_src != 64'd0));
    endfunction

    function automatic logic [3:0] m_cause();
        logic [63:0] p;
        p = m_mip & m_mie & 64'h888;
        if (p[11]) return 4'd11;
        if (p[3])  return 4'd3;
        if (p[7])  return 4'd7;
        return 4'd0;
    endfunction

    task automatic model_step();
        logic [63:0] old, nv, nmip;
        bit wrote_cyc, wrote_ret;
        wrote_cyc = 1'b0;
        wrote_ret = 1'b0;
        if (rst) begin
            m_mstatus = 64'h0000000a00001800;
            {m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval} = '0;
            {m_satp, m_mip, m_mcycle, m_minstret} = '0;
            m_valid = 1'b1;
            return;
        end
        nmip = (64'(meip) << 11) | (64'(mtip) << 7) | (64'(msip) << 3);
        if (wb_valid && (exc_valid || irq_take)) begin
            m_mepc   = 64'(trap_pc) & ~64'd3;
            m_mcause = exc_valid ? 64'(exc_cause) : ((64'd1 << 63) | 64'(m_cause()));
            m_mtval  = exc_valid ? exc_tval : 64'd0;
            m_mstatus[7] = m_mstatus[3];
            m_mstatus[3] = 1'b0;
        end else if (wb_valid && mret) begin
            m_mstatus[3] = m_mstatus[7];
            m_mstatus[7] = 1'b1;
        end else if (wb_valid && csr_op != 2'b00 && !m_illegal() &&
                     (csr_op == 2'b01 || csr_src != 64'd0)) begin
            old = m_rd(csr_addr);
            nv  = (csr_op == 2'b01) ? csr_src : (csr_op == 2'b10) ? (old | csr_src) : (old & ~csr_src);
            case (csr_addr)
                12'h300: m_mstatus  = nv | 64'h1800;
                12'h304: m_mie      = nv;
                12'h305: m_mtvec    = nv & ~64'd2;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc     = nv & 64'hFFFF_FFFC;
                12'h342: m_mcause   = nv;
                12'h343: m_mtval    = nv;
                12'h180: m_satp     = nv;
                12'hB00: begin m_mcycle   = nv; wrote_cyc = 1'b1; end
                12'hB02: begin m_minstret = nv; wrote_ret = 1'b1; end
                default: ;
            endcase
        end
        if (!wrote_cyc) m_mcycle = m_mcycle + 64'd1;
        if (!wrote_ret && wb_valid && retire) m_minstret = m_minstret + 64'd1;
        m_mip = nmip;
    endtask

    task automatic compare();
        logic [31:0] base, vec;
        bit          req;
        req  = ((m_mip & m_mie & 64'h888) != 64'd0) && m_mstatus[3] && !pipe_busy;
        base = m_mtvec[31:0] & ~32'd3;
        vec  = base;
        if (wb_valid && irq_take && !exc_valid && m_mtvec[0]) vec = base + 32'(m_cause()) * 32'd4;
        chk("cyc_rdata", csr_rdata, m_rd(csr_addr));
        chk("cyc_illegal", 64'(csr_illegal), 64'(m_illegal()));
        chk("cyc_irq_req", 64'(irq_req), 64'(req));
        if (req) chk("cyc_irq_cause", 64'(irq_cause), 64'(m_cause()));
        chk("cyc_trap_vec", 64'(trap_vec), 64'(vec));
        chk("cyc_mepc", 64'(mepc_out), m_mepc);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) compare();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wb, input logic [1:0] op, input logic [11:0] a, input logic [63:0] s);
        wb_valid = wb;
        csr_op   = op;
        csr_addr = a;
        csr_src  = s;
    endtask

    task automatic rd(input logic [11:0] a);
        drive(1'b0, 2'b00, a, 64'd0);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {msip, mtip, meip, pipe_busy, exc_valid, irq_take, mret, retire} = '0;
        exc_cause = 4'd0;
        exc_tval  = 64'd0;
        trap_pc   = 32'd0;
        drive(1'b0, 2'b00, 12'h000, 64'd0);
        repeat (3) tick();
        rst = 1'b0;

        rd(12'h300); chk("rst_mstatus", csr_rdata, 64'h0000000a00001800);
        rd(12'h305); chk("rst_mtvec", csr_rdata, 64'd0);
        chk("rst_irq_req", 64'(irq_req), 64'd0);
        chk("rst_trap_vec", 64'(trap_vec), 64'd0);
        chk("rst_mepc", 64'(mepc_out), 64'd0);

        drive(1'b1, 2'b01, 12'h304, 64'h80); tick();
        drive(1'b1, 2'b10, 12'h300, 64'h8); tick();
        drive(1'b0, 2'b00, 12'h300, 64'd0);
        mtip = 1'b1; #1;
        chk("mti_latency", 64'(irq_req), 64'd0);
        tick();
        chk("mti_req", 64'(irq_req), 64'd1);
        chk("mti_cause", 64'(irq_cause), 64'd7);
        pipe_busy = 1'b1; #1;
        chk("busy_mask", 64'(irq_req), 64'd0);
        pipe_busy = 1'b0;

        meip = 1'b1;
        drive(1'b1, 2'b01, 12'h304, 64'h880); tick();
        drive(1'b1, 2'b01, 12'h305, 64'h80000003); tick();
        rd(12'h305); chk("mtvec_warl", csr_rdata, 64'h80000001);
        chk("mei_over_mti", 64'(irq_cause), 64'd11);

        wb_valid = 1'b1; irq_take = 1'b1; trap_pc = 32'h80000104; #1;
        chk("irq_vector", 64'(trap_vec), 64'h8000002C);
        tick();
        irq_take = 1'b0;
        rd(12'h341); chk("irq_mepc", csr_rdata, 64'h80000104);
        rd(12'h342); chk("irq_mcause", csr_rdata, 64'h800000000000000B);
        rd(12'h300); chk("irq_mie_mpie", csr_rdata & 64'h88, 64'h80);
        chk("irq_off_after_trap", 64'(irq_req), 64'd0);

        wb_valid = 1'b1; mret = 1'b1; tick();
        mret = 1'b0;
        rd(12'h300); chk("mret_mie_mpie", csr_rdata & 64'h88, 64'h88);
        chk("mret_target", 64'(mepc_out), 64'h80000104);
        meip = 1'b0; mtip = 1'b0;

        drive(1'b1, 2'b01, 12'h340, 64'h0F); tick();
        drive(1'b1, 2'b10, 12'h340, 64'hF0); #1;
        chk("rs_old", csr_rdata, 64'h0F);
        tick();
        rd(12'h340); chk("rs_new", csr_rdata, 64'hFF);
        drive(1'b1, 2'b11, 12'h340, 64'h0F); #1;
        chk("rc_old", csr_rdata, 64'hFF);
        tick();
        rd(12'h340); chk("rc_new", csr_rdata, 64'hF0);

        drive(1'b1, 2'b01, 12'h344, 64'h888); #1;
        chk("mip_write_illegal", 64'(csr_illegal), 64'd1);
        tick();
        drive(1'b1, 2'b10, 12'h344, 64'd0); #1;
        chk("mip_rs0_legal", 64'(csr_illegal), 64'd0);
        chk("mip_unchanged", csr_rdata, 64'd0);
        drive(1'b1, 2'b01, 12'hF14, 64'd1); #1;
        chk("mhartid_write_illegal", 64'(csr_illegal), 64'd1);
        drive(1'b1, 2'b10, 12'h7C0, 64'd0); #1;
        chk("unimpl_illegal", 64'(csr_illegal), 64'd1);
        chk("unimpl_rdata", csr_rdata, 64'd0);

        drive(1'b1, 2'b01, 12'h340, 64'hAA);
        exc_valid = 1'b1; exc_cause = 4'd2; exc_tval = 64'h1234; trap_pc = 32'h80000202;
        mret = 1'b1; irq_take = 1'b1; #1;
        chk("exc_vector_base", 64'(trap_vec), 64'h80000000);
        tick();
        {exc_valid, mret, irq_take} = '0;
        rd(12'h340); chk("collide_mscratch", csr_rdata, 64'hF0);
        rd(12'h342); chk("exc_mcause", csr_rdata, 64'd2);
        rd(12'h343); chk("exc_mtval", csr_rdata, 64'h1234);
        rd(12'h341); chk("exc_mepc", csr_rdata, 64'h80000200);
        rd(12'h300); chk("exc_mie_mpie", csr_rdata & 64'h88, 64'h80);

        drive(1'b1, 2'b01, 12'h341, 64'h80000207); tick();
        rd(12'h341); chk("mepc_warl", csr_rdata, 64'h80000204);
        drive(1'b1, 2'b01, 12'h300, 64'd0); tick();
        rd(12'h300); chk("mpp_hardwired", csr_rdata, 64'h1800);
        drive(1'b1, 2'b01, 12'h180, 64'h8000000000012345); retire = 1'b1; tick();
        retire = 1'b0;
        rd(12'h180); chk("satp_rw", csr_rdata, 64'h8000000000012345);

`ifdef CSR_COUNTERS_EN
        drive(1'b1, 2'b01, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF); tick();
        rd(12'hB00); chk("mcycle_written", csr_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        rd(12'hB00); chk("mcycle_wrap", csr_rdata, 64'd0);
        drive(1'b1, 2'b01, 12'hB02, 64'd5); retire = 1'b1; tick();
        drive(1'b1, 2'b00, 12'hB02, 64'd0); tick();
        retire = 1'b0;
        rd(12'hB02); chk("minstret_count", csr_rdata, 64'd6);
`else
        drive(1'b1, 2'b10, 12'hB00, 64'd0); #1;
        chk("mcycle_absent_illegal", 64'(csr_illegal), 64'd1);
        chk("mcycle_absent_rdata", csr_rdata, 64'd0);
        drive(1'b1, 2'b10, 12'hB02, 64'd0); #1;
        chk("minstret_absent_illegal", 64'(csr_illegal), 64'd1);
`endif

        drive(1'b1, 2'b01, 12'h340, 64'h55); msip = 1'b1; rst = 1'b1; tick();
        rst = 1'b0;
        rd(12'h340); chk("midrst_mscratch", csr_rdata, 64'd0);
        rd(12'h344); chk("midrst_mip", csr_rdata, 64'd0);
        rd(12'h300); chk("midrst_mstatus", csr_rdata, 64'h0000000a00001800);
        tick();
        rd(12'h344); chk("post_rst_mip", csr_rdata, 64'h8);
        msip = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
